// File: rtl/tri_job_arbiter.sv
// Purpose: shares one triangle engine between two requesters; round-robin grant, vertex replay, owner-tagged pixel forwarding.
// Latency: vertex 1 reaches the engine one cycle after accept; pixels are forwarded one cycle after eng_po is sampled.
// Backpressure: reqN_ready is only high in IDLE with the engine idle; a job holds the engine until job_done.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req0_*/req1_*              valid/ready triangle submission, tri = {x1,y1,x2,y2,x3,y3}
//   eng_nt/eng_xi/eng_yi       vertex replay to the engine (nt high with vertex 1)
//   eng_busy/eng_po/eng_xo/yo  engine status and rendered pixel stream
//   pix_valid/x/y/owner        forwarded pixel tagged with its requester
//   job_done/owner/pixels/err  one-cycle completion report (err = busy never rose)
module tri_job_arbiter #(
    parameter int COORD_W      = 3,
    parameter int CNT_W        = 7,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [6*COORD_W-1:0] req0_tri,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [6*COORD_W-1:0] req1_tri,
    output logic                 req1_ready,
    output logic                 eng_nt,
    output logic [COORD_W-1:0]   eng_xi,
    output logic [COORD_W-1:0]   eng_yi,
    input  logic                 eng_busy,
    input  logic                 eng_po,
    input  logic [COORD_W-1:0]   eng_xo,
    input  logic [COORD_W-1:0]   eng_yo,
    output logic                 pix_valid,
    output logic [COORD_W-1:0]   pix_x,
    output logic [COORD_W-1:0]   pix_y,
    output logic                 pix_owner,
    output logic                 job_done,
    output logic                 job_owner,
    output logic [CNT_W-1:0]     job_pixels,
    output logic                 job_err
);

    localparam int TRI_W = 6 * COORD_W;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_V1,
        S_V2,
        S_V3,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TRI_W-1:0]   tri_q;
    logic               owner_q;
    logic               last_grant;
    logic [TO_W-1:0]    to_cnt;
    logic [CNT_W-1:0]   pix_cnt;
    logic               err_q;

    logic               grant;
    logic               accept;
    logic               timeout_hit;
    logic               sample_en;
    logic               fwd;

    // With no contention the sole valid requester wins; with both valid the
    // one not served last time wins. With neither valid grant is a don't-care.
    always_comb begin
        grant       = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        req0_ready  = (state == S_IDLE) && !eng_busy && !grant;
        req1_ready  = (state == S_IDLE) && !eng_busy &&  grant;
        accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        timeout_hit = (state == S_WAIT_BUSY) && !eng_busy &&
                      (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
        // Pixels are accepted while waiting for busy and throughout RUN,
        // including the cycle in which busy drops.
        sample_en   = (state == S_WAIT_BUSY) || (state == S_RUN);
        fwd         = sample_en && eng_po;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_V1;
            S_V1:        state_nxt = S_V2;
            S_V2:        state_nxt = S_V3;
            S_V3:        state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (eng_busy)         state_nxt = S_RUN;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_RUN:       if (!eng_busy) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Vertex replay: the triangle is packed x1,y1,x2,y2,x3,y3 from the MSB down.
    always_comb begin
        eng_nt = 1'b0;
        eng_xi = '0;
        eng_yi = '0;
        case (state)
            S_V1: begin
                eng_nt = 1'b1;
                eng_xi = tri_q[TRI_W-1           -: COORD_W];
                eng_yi = tri_q[TRI_W-1-COORD_W   -: COORD_W];
            end
            S_V2: begin
                eng_xi = tri_q[TRI_W-1-2*COORD_W -: COORD_W];
                eng_yi = tri_q[TRI_W-1-3*COORD_W -: COORD_W];
            end
            S_V3: begin
                eng_xi = tri_q[2*COORD_W-1       -: COORD_W];
                eng_yi = tri_q[COORD_W-1         -: COORD_W];
            end
            default: ;
        endcase
    end

    // Job report fields are held at zero except during the DONE cycle.
    always_comb begin
        job_done   = (state == S_DONE);
        job_owner  = job_done && owner_q;
        job_err    = job_done && err_q;
        job_pixels = job_done ? pix_cnt : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tri_q      <= '0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            to_cnt     <= '0;
            pix_cnt    <= '0;
            err_q      <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_owner  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                tri_q      <= grant ? req1_tri : req0_tri;
                owner_q    <= grant;
                last_grant <= grant;
                err_q      <= 1'b0;
            end

            if (state == S_V3) begin
                to_cnt <= '0;
            end else if (state == S_WAIT_BUSY) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (timeout_hit) begin
                err_q <= 1'b1;
            end

            pix_valid <= fwd;
            pix_x     <= fwd ? eng_xo : '0;
            pix_y     <= fwd ? eng_yo : '0;
            pix_owner <= fwd && owner_q;

            // Counted at sample time so a pixel taken in the last RUN cycle
            // is already included when DONE reports the total.
            if (state == S_DONE) begin
                pix_cnt <= '0;
            end else if (fwd && (pix_cnt != '1)) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tri_job_arbiter.sv
// Purpose: directed bench for tri_job_arbiter; second instance with a 3-bit pixel counter shares the stimulus.
// Latency: inputs change on the falling edge, outputs are compared 1 time unit later.
// Backpressure: the bench plays the engine itself and holds or drops request valids per step.
module tb_tri_job_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [17:0] req0_tri, req1_tri;
    logic       req0_ready, req1_ready;
    logic       eng_nt;
    logic [2:0] eng_xi, eng_yi;
    logic       eng_busy, eng_po;
    logic [2:0] eng_xo, eng_yo;
    logic       pix_valid, pix_owner;
    logic [2:0] pix_x, pix_y;
    logic       job_done, job_owner, job_err;
    logic [6:0] job_pixels;

    logic       req0_ready3, req1_ready3, eng_nt3;
    logic [2:0] eng_xi3, eng_yi3, pix_x3, pix_y3;
    logic       pix_valid3, pix_owner3, job_done3, job_owner3, job_err3;
    logic [2:0] job_pixels3;

    int vectors    = 0;
    int miscompares = 0;
    int pv_cnt = 0, pv3_cnt = 0, cks = 0, bad_owner = 0;
    logic cur_owner = 1'b0;

    localparam logic [17:0] T1 = {3'd1, 3'd1, 3'd6, 3'd1, 3'd1, 3'd6};
    localparam logic [17:0] TA = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [17:0] TB = {3'd7, 3'd0, 3'd5, 3'd1, 3'd3, 3'd2};

    tri_job_arbiter u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_tri(req0_tri), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_tri(req1_tri), .req1_ready(req1_ready),
        .eng_nt(eng_nt), .eng_xi(eng_xi), .eng_yi(eng_yi),
        .eng_busy(eng_busy), .eng_po(eng_po), .eng_xo(eng_xo), .eng_yo(eng_yo),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_owner(pix_owner),
        .job_done(job_done), .job_owner(job_owner), .job_pixels(job_pixels), .job_err(job_err)
    );

    tri_job_arbiter #(.CNT_W(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_tri(req0_tri), .req0_ready(req0_ready3),
        .req1_valid(req1_valid), .req1_tri(req1_tri), .req1_ready(req1_ready3),
        .eng_nt(eng_nt3), .eng_xi(eng_xi3), .eng_yi(eng_yi3),
        .eng_busy(eng_busy), .eng_po(eng_po), .eng_xo(eng_xo), .eng_yo(eng_yo),
        .pix_valid(pix_valid3), .pix_x(pix_x3), .pix_y(pix_y3), .pix_owner(pix_owner3),
        .job_done(job_done3), .job_owner(job_owner3), .job_pixels(job_pixels3), .job_err(job_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Pixel monitor, sampled well after the falling-edge comparisons.
    always @(negedge clk) begin
        #2;
        if (pix_valid === 1'b1) begin
            pv_cnt = pv_cnt + 1;
            cks    = cks + int'({pix_x, pix_y}) + 1;
            if (pix_owner !== cur_owner) bad_owner = bad_owner + 1;
        end
        if (pix_valid3 === 1'b1) pv3_cnt = pv3_cnt + 1;
    end

    // Lattice points of triangle (1,1)(6,1)(1,6): x,y >= 1 and x+y <= 7 (21 points).
    function automatic logic [5:0] tri_pt(input int idx);
        int k;
        logic [5:0] r;
        k = 0;
        r = '0;
        for (int x = 1; x <= 6; x++) begin
            for (int y = 1; y <= 7 - x; y++) begin
                if (k == idx % 21) r = {x[2:0], y[2:0]};
                k++;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered at the falling edge of the IDLE cycle in which the request is
    // expected to be accepted; returns at the DONE cycle (+3 time units).
    task automatic do_job(input logic own, input logic [17:0] t, input int n,
                          input bit fall, input bit hold, input bit timeout);
        int base, base3, c0, exp_cks;
        cur_owner = own;
        base  = pv_cnt;
        base3 = pv3_cnt;
        c0    = cks;
        exp_cks = 0;
        for (int i = 0; i < n; i++) exp_cks += int'(tri_pt(i)) + 1;
        #1;
        chk("ready_owner", own ? req1_ready : req0_ready, 1);
        chk("ready_other", own ? req0_ready : req1_ready, 0);
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            if (v == 0 && !hold) begin
                if (own) req1_valid = 1'b0; else req0_valid = 1'b0;
            end
            #1;
            chk("eng_nt", eng_nt, (v == 0) ? 1 : 0);
            chk("eng_xi", eng_xi, t[17-6*v -: 3]);
            chk("eng_yi", eng_yi, t[14-6*v -: 3]);
        end
        if (timeout) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); #1;
                chk("early_done", job_done, 0);
            end
        end else begin
            @(negedge clk);
            eng_busy = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                eng_po = 1'b1;
                {eng_xo, eng_yo} = tri_pt(i);
                if (fall && i == n - 1) eng_busy = 1'b0;
            end
            if (!fall) begin
                @(negedge clk);
                eng_po   = 1'b0;
                eng_busy = 1'b0;
            end
        end
        @(negedge clk);
        eng_po   = 1'b0;
        eng_busy = 1'b0;
        #1;
        chk("job_done", job_done, 1);
        chk("job_owner", job_owner, own);
        chk("job_err", job_err, timeout);
        chk("job_pixels", job_pixels, n);
        chk("job_pixels_sat", job_pixels3, (n > 7) ? 7 : n);
        chk("pix_at_done", pix_valid, (fall && !timeout) ? 1 : 0);
        chk("ready_in_done", {req0_ready, req1_ready}, 0);
        #2;
        chk("pix_count", pv_cnt - base, n);
        chk("pix_count_sat_dut", pv3_cnt - base3, n);
        chk("pix_checksum", cks - c0, exp_cks);
        chk("pix_owner_bad", bad_owner, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_tri = '0; req1_tri = '0;
        eng_busy = 1'b0; eng_po = 1'b0; eng_xo = '0; eng_yo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_nt", eng_nt, 0);
        chk("rst_xy", {eng_xi, eng_yi}, 0);
        chk("rst_pix", {pix_valid, pix_x, pix_y, pix_owner}, 0);
        chk("rst_job", {job_done, job_owner, job_pixels, job_err}, 0);

        // Single req0 job, 21 pixels.
        @(negedge clk);
        req0_valid = 1'b1; req0_tri = T1;
        do_job(1'b0, T1, 21, 1'b0, 1'b0, 1'b0);

        // Engine busy while idle blocks both grants.
        @(negedge clk);
        eng_busy = 1'b1; req0_valid = 1'b1; req0_tri = TA;
        #1;
        chk("busy_block", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        eng_busy = 1'b0;
        do_job(1'b0, TA, 2, 1'b1, 1'b0, 1'b0);

        // Fresh reset so the tie order starts from requester 0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_job", {job_done, job_pixels}, 0);

        // Both requesters held valid across four jobs: 0,1,0,1.
        @(negedge clk);
        req0_valid = 1'b1; req0_tri = TA;
        req1_valid = 1'b1; req1_tri = TB;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            do_job(j[0], j[0] ? TB : TA, 2 + j, j[0], 1'b1, 1'b0);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Engine never raises busy: timeout.
        @(negedge clk);
        req1_valid = 1'b1; req1_tri = TA;
        do_job(1'b1, TA, 0, 1'b0, 1'b0, 1'b1);

        // Reset during V2, then req1 served normally.
        @(negedge clk);
        req0_valid = 1'b1; req0_tri = TB;
        #1;
        chk("t4_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("t4_v1_nt", eng_nt, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_v2_x", {eng_xi, eng_yi}, {3'd5, 3'd1});
        @(negedge clk);
        reset = 1'b0;
        req1_valid = 1'b1; req1_tri = T1;
        #1;
        chk("t4_post_nt", eng_nt, 0);
        chk("t4_post_xy", {eng_xi, eng_yi}, 0);
        chk("t4_no_done", job_done, 0);
        do_job(1'b1, T1, 4, 1'b1, 1'b0, 1'b0);

        // Pixel pulse in IDLE is dropped; final pixel on busy fall is kept.
        @(negedge clk);
        eng_po = 1'b1; eng_xo = 3'd5; eng_yo = 3'd2;
        @(negedge clk);
        eng_po = 1'b0;
        #1;
        chk("idle_po_dropped", pix_valid, 0);
        req0_valid = 1'b1; req0_tri = TA;
        do_job(1'b0, TA, 3, 1'b1, 1'b0, 1'b0);

        // Ten pixels: full-width count 10, 3-bit counter saturates at 7.
        @(negedge clk);
        req0_valid = 1'b1; req0_tri = T1;
        do_job(1'b0, T1, 10, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
